// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  localparam int XLEN           = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles a little-endian byte stream into XLEN-bit words; byte k lands in
// bits [8k+7:8k]. Clearing zeroes the register so partial words pad with 0.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            accept,
  input  logic [7:0]      byte_data,
  output logic            word_full,
  output logic [XLEN-1:0] word
);

  logic [IDX_W-1:0] idx_reg;
  logic [XLEN-1:0]  asm_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
      asm_reg <= '0;
    end else if (clear) begin
      idx_reg <= '0;
      asm_reg <= '0;
    end else if (accept) begin
      asm_reg[8*idx_reg +: 8] <= byte_data;
      idx_reg                 <= idx_reg + 1'b1;
    end
  end

  // High while the next accepted byte completes the word.
  assign word_full = (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
  assign word      = asm_reg;

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of the words written.
module imem_loader
  import imem_pkg::*;
#(
  parameter int              DEPTH     = 256,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [XLEN-1:0]        checksum
`endif
);

  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic            last_reg;
  logic            overflow_reg;
  logic            session_start;
  logic            accept;
  logic            at_capacity;
  logic            word_full;
  logic            packer_clear;
  logic [XLEN-1:0] word;

  assign session_start = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign accept        = byte_valid && (state_reg == ST_LOAD);
  assign at_capacity   = (count_reg == FULL_COUNT);
  assign packer_clear  = session_start || (state_reg == ST_WRITE);

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (packer_clear),
    .accept    (accept),
    .byte_data (byte_data),
    .word_full (word_full),
    .word      (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD:          if (accept && (word_full || byte_last)) state_next = ST_WRITE;
      ST_WRITE:         state_next = (at_capacity || last_reg) ? ST_DONE : ST_LOAD;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_reg == ST_LOAD);
    busy       = (state_reg == ST_LOAD) || (state_reg == ST_WRITE);
    done       = (state_reg == ST_DONE);
    mem_we     = (state_reg == ST_WRITE) && !at_capacity;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_we) begin
      mem_addr  = BASE_ADDR + (XLEN'(count_reg) << 2);
      mem_wdata = word;
    end
  end

  // A WRITE at capacity is the overflow point: the word is dropped, not written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      last_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (session_start) begin
      count_reg    <= '0;
      last_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept && byte_last) last_reg <= 1'b1;
      if (state_reg == ST_WRITE) begin
        if (at_capacity) overflow_reg <= 1'b1;
        else             count_reg    <= count_reg + 1'b1;
      end
    end
  end

  assign overflow   = overflow_reg;
  assign word_count = count_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [XLEN-1:0] checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             checksum_reg <= '0;
    else if (session_start) checksum_reg <= '0;
    else if (mem_we)        checksum_reg <= checksum_reg ^ word;
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a default instance plus a DEPTH=4 instance fed the
// same byte stream, both checked against a word-packing model of the image.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int          SMALL_DEPTH = 4;
  localparam logic [31:0] SMALL_BASE  = 32'h8000_0100;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic byte_valid = 1'b0;
  logic byte_last = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic b_ready, b_we, b_busy, b_done, b_ovf;
  logic [31:0] b_addr, b_wdata;
  logic [8:0] b_count;
  logic s_ready, s_we, s_busy, s_done, s_ovf;
  logic [31:0] s_addr, s_wdata;
  logic [2:0] s_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] b_csum, s_csum;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] b_aq[$], b_dq[$], s_aq[$], s_dq[$];
  int bad_ready = 0;

  always #5 clk = ~clk;

  imem_loader u_big (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(b_ready),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .busy(b_busy),
    .done(b_done), .overflow(b_ovf), .word_count(b_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(b_csum)
`endif
  );

  imem_loader #(.DEPTH(SMALL_DEPTH), .BASE_ADDR(SMALL_BASE)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(s_ready),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .busy(s_busy),
    .done(s_done), .overflow(s_ovf), .word_count(s_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(s_csum)
`endif
  );

  // Write capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (b_we) begin
      b_aq.push_back(b_addr);
      b_dq.push_back(b_wdata);
      if (b_ready) bad_ready++;
    end
    if (s_we) begin
      s_aq.push_back(s_addr);
      s_dq.push_back(s_wdata);
      if (s_ready) bad_ready++;
    end
  end

  // Reference: little-endian packing, final partial word zero-padded.
  function automatic word_q_t pack_words(input byte_q_t img);
    word_q_t w;
    logic [31:0] cur = 32'h0;
    for (int i = 0; i < img.size(); i++) begin
      cur = cur | (32'(img[i]) << (8 * (i % 4)));
      if ((i % 4) == 3 || i == img.size() - 1) begin
        w.push_back(cur);
        cur = 32'h0;
      end
    end
    return w;
  endfunction

  function automatic byte_q_t rand_image(input int len);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic clear_capture();
    b_aq.delete(); b_dq.delete(); s_aq.delete(); s_dq.delete();
    bad_ready = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid toggles each cycle, 2: random gaps
  // with junk on idle cycles and stray start pulses while busy.
  task automatic drive_bytes(input byte_q_t img, input int mode, input int stop_after,
                             output bit timed_out);
    int idx = 0;
    int waited = 0;
    int n;
    bit v = 1'b0;
    timed_out = 1'b0;
    n = (stop_after > 0) ? stop_after : img.size();
    while (idx < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = !v;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid = v;
      byte_data  = v ? img[idx] : 8'($urandom);
      byte_last  = v ? (idx == img.size() - 1) : 1'($urandom);
      start      = (mode == 2) && s_busy && ($urandom_range(0, 7) == 0);
      if (v && b_ready) begin
        idx++;
        waited = 0;
      end else begin
        waited++;
      end
      if (waited > 40) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b0;
  endtask

  // Full session; afterwards feed bytes in DONE, which must be ignored.
  task automatic run_session(input byte_q_t img, input int mode, output bit timed_out);
    bit to_drive;
    int c = 0;
    clear_capture();
    do_start();
    drive_bytes(img, mode, 0, to_drive);
    timed_out = to_drive;
    while (!(b_done && s_done) && !timed_out) begin
      @(negedge clk);
      c++;
      if (c > 50) timed_out = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      byte_last  = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({b_ready, b_we, b_busy, b_done, b_ovf, b_addr, b_wdata, b_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_big: outputs=%h required all zero",
               {b_ready, b_we, b_busy, b_done, b_ovf, b_addr, b_wdata, b_count});
    end
    vectors++;
    if ({s_ready, s_we, s_busy, s_done, s_ovf, s_addr, s_wdata, s_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_small: outputs=%h required all zero",
               {s_ready, s_we, s_busy, s_done, s_ovf, s_addr, s_wdata, s_count});
    end
`ifdef LOADER_CHECKSUM_EN
    vectors++;
    if ({b_csum, s_csum} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_checksum: got %h/%h required 0", b_csum, s_csum);
    end
`endif
    start = 1'b0;
    byte_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: applied and released");
  endtask

  task automatic test_single_word();
    byte_q_t img = '{8'h13, 8'h00, 8'h50, 8'h00};
    bit to;
    run_session(img, 0, to);
    vectors++;
    if (to || b_aq.size() != 1 || s_aq.size() != 1) begin
      miscompares++;
      $display("FAIL single_writes: timeout=%0d big=%0d small=%0d required 1/1",
               to, b_aq.size(), s_aq.size());
    end else begin
      vectors++;
      if (b_aq[0] !== 32'h0 || b_dq[0] !== 32'h0050_0013) begin
        miscompares++;
        $display("FAIL single_big: addr=%h data=%h required 00000000/00500013", b_aq[0], b_dq[0]);
      end
      vectors++;
      if (s_aq[0] !== SMALL_BASE || s_dq[0] !== 32'h0050_0013) begin
        miscompares++;
        $display("FAIL single_small: addr=%h data=%h required %h/00500013",
                 s_aq[0], s_dq[0], SMALL_BASE);
      end
    end
    vectors++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_count !== 9'd1 || b_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL single_status: done=%b busy=%b count=%0d ovf=%b required 1/0/1/0",
               b_done, b_busy, b_count, b_ovf);
    end
    $display("single_word: writes=%0d count=%0d", b_aq.size(), b_count);
  endtask

  task automatic test_toggle_valid();
    byte_q_t img = rand_image(8);
    word_q_t exp = pack_words(img);
    bit to;
    run_session(img, 1, to);
    vectors++;
    if (to || b_aq.size() != 2) begin
      miscompares++;
      $display("FAIL toggle_writes: timeout=%0d writes=%0d required 2", to, b_aq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (b_aq[i] !== 32'(4 * i) || b_dq[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL toggle_word%0d: addr=%h data=%h required %h/%h",
                   i, b_aq[i], b_dq[i], 32'(4 * i), exp[i]);
        end
      end
    end
    vectors++;
    if (bad_ready != 0) begin
      miscompares++;
      $display("FAIL toggle_ready_in_write: %0d cycles with byte_ready during write, required 0",
               bad_ready);
    end
    $display("toggle_valid: writes=%0d", b_aq.size());
  endtask

  task automatic test_partial_word();
    byte_q_t img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    bit to;
    run_session(img, 2, to);
    vectors++;
    if (to || b_aq.size() != 2) begin
      miscompares++;
      $display("FAIL partial_writes: timeout=%0d writes=%0d required 2", to, b_aq.size());
    end else begin
      vectors++;
      if (b_dq[0] !== 32'hDDCC_BBAA || b_aq[1] !== 32'h4 || b_dq[1] !== 32'h0000_00EE) begin
        miscompares++;
        $display("FAIL partial_data: w0=%h a1=%h w1=%h required DDCCBBAA/00000004/000000EE",
                 b_dq[0], b_aq[1], b_dq[1]);
      end
    end
    vectors++;
    if (b_count !== 9'd2 || b_done !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_status: count=%0d done=%b required 2/1", b_count, b_done);
    end
    $display("partial_word: writes=%0d", b_aq.size());
  endtask

  task automatic test_overflow();
    byte_q_t img = rand_image(20);
    word_q_t exp = pack_words(img);
    bit to;
    run_session(img, 0, to);
    vectors++;
    if (to || s_aq.size() != 4 || b_aq.size() != 5) begin
      miscompares++;
      $display("FAIL ovf_writes: timeout=%0d small=%0d big=%0d required 4/5",
               to, s_aq.size(), b_aq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (s_aq[i] !== SMALL_BASE + 32'(4 * i) || s_dq[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL ovf_word%0d: addr=%h data=%h required %h/%h",
                   i, s_aq[i], s_dq[i], SMALL_BASE + 32'(4 * i), exp[i]);
        end
      end
    end
    vectors++;
    if (s_ovf !== 1'b1 || s_done !== 1'b1 || s_count !== 3'd4 || b_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_status: ovf=%b done=%b count=%0d big_ovf=%b required 1/1/4/0",
               s_ovf, s_done, s_count, b_ovf);
    end
    $display("overflow: small writes=%0d overflow=%b", s_aq.size(), s_ovf);
  endtask

  task automatic test_reset_abort();
    byte_q_t img = rand_image(8);
    byte_q_t img2 = rand_image(4);
    word_q_t exp2 = pack_words(img2);
    bit to;
    clear_capture();
    do_start();
    drive_bytes(img, 0, 6, to);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (to || b_aq.size() != 1 || s_aq.size() != 1 || b_busy !== 1'b0 || b_count !== 9'd0) begin
      miscompares++;
      $display("FAIL abort_quiet: timeout=%0d writes=%0d/%0d busy=%b count=%0d required 0 1/1 0 0",
               to, b_aq.size(), s_aq.size(), b_busy, b_count);
    end
    run_session(img2, 0, to);
    vectors++;
    if (to || b_aq.size() != 1 || s_aq.size() != 1) begin
      miscompares++;
      $display("FAIL abort_restart: timeout=%0d writes=%0d/%0d required 1/1", to, b_aq.size(), s_aq.size());
    end else begin
      vectors++;
      if (b_aq[0] !== 32'h0 || b_dq[0] !== exp2[0] || s_aq[0] !== SMALL_BASE) begin
        miscompares++;
        $display("FAIL abort_restart_data: addr=%h data=%h small_addr=%h required 00000000/%h/%h",
                 b_aq[0], b_dq[0], s_aq[0], exp2[0], SMALL_BASE);
      end
    end
    $display("reset_abort: restart writes=%0d", b_aq.size());
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int len = $urandom_range(1, 24);
      int mode = $urandom_range(0, 2);
      byte_q_t img = rand_image(len);
      word_q_t exp = pack_words(img);
      int n = exp.size();
      int sn = (n > SMALL_DEPTH) ? SMALL_DEPTH : n;
      int errs = 0;
      bit to;
      logic [31:0] bx = 32'h0;
      logic [31:0] sx = 32'h0;
      run_session(img, mode, to);
      vectors++;
      if (to || b_aq.size() != n || s_aq.size() != sn) begin
        miscompares++;
        errs++;
        $display("FAIL rand%0d_writes: timeout=%0d big=%0d small=%0d required %0d/%0d",
                 t, to, b_aq.size(), s_aq.size(), n, sn);
      end else begin
        for (int i = 0; i < n; i++) begin
          bx = bx ^ exp[i];
          if (i < sn) sx = sx ^ exp[i];
          vectors++;
          if (b_aq[i] !== 32'(4 * i) || b_dq[i] !== exp[i] ||
              (i < sn && (s_aq[i] !== SMALL_BASE + 32'(4 * i) || s_dq[i] !== exp[i]))) begin
            miscompares++;
            errs++;
            $display("FAIL rand%0d_word%0d: addr=%h data=%h required %h/%h",
                     t, i, b_aq[i], b_dq[i], 32'(4 * i), exp[i]);
          end
        end
      end
      vectors++;
      if (b_count !== 9'(n) || s_count !== 3'(sn) || s_ovf !== (n > SMALL_DEPTH) ||
          b_ovf !== 1'b0 || b_done !== 1'b1 || s_done !== 1'b1 || bad_ready != 0) begin
        miscompares++;
        errs++;
        $display("FAIL rand%0d_status: cnt=%0d/%0d ovf=%b/%b done=%b/%b rdy_err=%0d required %0d/%0d 0/%b 1/1 0",
                 t, b_count, s_count, b_ovf, s_ovf, b_done, s_done, bad_ready,
                 n, sn, (n > SMALL_DEPTH));
      end
`ifdef LOADER_CHECKSUM_EN
      vectors++;
      if (b_csum !== bx || s_csum !== sx) begin
        miscompares++;
        errs++;
        $display("FAIL rand%0d_checksum: got %h/%h required %h/%h", t, b_csum, s_csum, bx, sx);
      end
`endif
      $display("random %0d: bytes=%0d mode=%0d words=%0d errors=%0d", t, len, mode, n, errs);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    bit to;
    run_session(img, 0, to);
    vectors++;
    if (to || b_csum !== 32'h1D3B_5977) begin
      miscompares++;
      $display("FAIL checksum: timeout=%0d got %h required 1D3B5977", to, b_csum);
    end
    $display("checksum: %h", b_csum);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_toggle_valid();
    test_partial_word();
    test_overflow();
    test_reset_abort();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, instruction memory size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of first written word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port byte_valid  input  1  byte_data is valid.
REQ-007 SHALL have port byte_data  input  8  program byte, little-endian stream order.
REQ-008 SHALL have port byte_last  input  1  marks final byte of the image; qualified by byte_valid.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-011 SHALL have port mem_addr  output  32  byte address of the write, always word aligned.
REQ-012 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  session finished; sticky until next start.
REQ-015 SHALL have port overflow  output  1  image exceeded DEPTH words; sticky until next start.
REQ-016 SHALL have port word_count  output  $clog2(DEPTH)+1  words written this session.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE or DONE + start: SHALL go to LOAD; clear word_count, byte index, assembly register, done, overflow.
REQ-019 start in LOAD or WRITE SHALL be ignored.
REQ-020 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid && byte_ready.
REQ-021 Accepted byte k (k=0..3) of a word SHALL land in bits [8k+7:8k] of the assembly register.
REQ-022 On acceptance of byte 3 or any byte with byte_last, SHALL go to WRITE next cycle.
REQ-023 Partial final word: unreceived upper bytes SHALL be zero.
REQ-024 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=BASE_ADDR+4*word_count, mem_wdata=assembly register; word_count increments at the end of the cycle.
REQ-025 After WRITE: SHALL go to DONE if the word held byte_last, else to LOAD with byte index 0.
REQ-026 Entering WRITE when word_count==DEPTH: mem_we SHALL stay 0, overflow SHALL set, FSM SHALL go to DONE.
REQ-027 busy SHALL be 1 in LOAD and WRITE; done SHALL be 1 in DONE only.
REQ-028 mem_we SHALL be 0 in all states except WRITE; mem_addr/mem_wdata don't-care while mem_we=0.
REQ-029 byte_valid in IDLE, WRITE or DONE SHALL be ignored (no acceptance, no state change).

Reset
REQ-030 rst_n low SHALL immediately force IDLE and zero all outputs, counters and assembly register.
REQ-031 Reset mid-session SHALL abort with no further mem_we; a restart requires a fresh start.

Configuration
REQ-032 With LOADER_CHECKSUM_EN defined, SHALL add output checksum [31:0]: XOR of all words written this session, cleared on start, updated in WRITE, valid while done=1.
REQ-033 Without LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package imem_pkg SHALL hold the state enum type, XLEN=32 and BYTES_PER_WORD=4 constants.
REQ-035 Sub-module imem_byte_packer SHALL own byte index and assembly register; FSM and address counter remain in imem_loader.

Verification
REQ-036 Bytes 13,00,50,00 with last on the 4th -> one write: addr 0x0, data 0x0050_0013; done=1; word_count=1.
REQ-037 8 bytes, byte_valid toggling every cycle -> writes at 0x0 and 0x4; byte_ready=0 during each WRITE cycle.
REQ-038 5 bytes AA,BB,CC,DD,EE with last on EE -> second write data 0x0000_00EE at 0x4.
REQ-039 DEPTH=4, 20 bytes -> 4 writes, 5th suppressed, overflow=1, done=1, word_count=4.
REQ-040 rst_n low after 2 bytes of word 1 -> no mem_we afterwards; start then 4 bytes -> write at BASE_ADDR.
REQ-041 LOADER_CHECKSUM_EN, words 0x1234_5678 and 0x0F0F_0F0F -> checksum 0x1D3B_5977.
